// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single read/write commands into classic Wishbone
// cycles, with bounded retry on wb_rty_i and an abort timer for slaves that
// never terminate. One response pulse is produced per accepted command.
module wb_cmd_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [aw-1:0]   cmd_adr,
    input  logic [dw-1:0]   cmd_dat,
    input  logic [3:0]      cmd_sel,
    output logic            rsp_valid,
    output logic [dw-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [3:0]      wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    // The abort fires on the edge that would bring the count to TIMEOUT,
    // so stb stays high for exactly TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] RTY_MAX = 4'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

    state_t          state, state_nxt;
    logic [7:0]      to_cnt, to_cnt_nxt;
    logic [3:0]      rty_cnt, rty_cnt_nxt;
    logic            cyc_nxt, stb_nxt, we_nxt;
    logic [aw-1:0]   adr_nxt;
    logic [dw-1:0]   dat_nxt;
    logic [3:0]      sel_nxt;
    logic            rsp_valid_nxt;
    logic [dw-1:0]   rsp_dat_nxt;
    logic [1:0]      rsp_status_nxt;
    logic            done;
    logic [1:0]      done_status;
    logic [dw-1:0]   done_dat;

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    // Ready is withheld during the response cycle so a completion and a new
    // acceptance never coincide.
    assign cmd_ready = (state == IDLE) && !rsp_valid && !wb_rst;

    // Next-state and next-output logic; every bus termination funnels into
    // one common completion path below the case statement.
    always_comb begin
        state_nxt      = state;
        to_cnt_nxt     = to_cnt;
        rty_cnt_nxt    = rty_cnt;
        cyc_nxt        = wb_cyc_o;
        stb_nxt        = wb_stb_o;
        we_nxt         = wb_we_o;
        adr_nxt        = wb_adr_o;
        dat_nxt        = wb_dat_o;
        sel_nxt        = wb_sel_o;
        rsp_valid_nxt  = 1'b0;
        rsp_dat_nxt    = rsp_dat;
        rsp_status_nxt = rsp_status;
        done           = 1'b0;
        done_status    = ST_OK;
        done_dat       = '0;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_nxt      = cmd_we;
                    adr_nxt     = cmd_adr;
                    dat_nxt     = cmd_dat;
                    sel_nxt     = cmd_sel;
                    cyc_nxt     = 1'b1;
                    stb_nxt     = 1'b1;
                    to_cnt_nxt  = '0;
                    rty_cnt_nxt = '0;
                    state_nxt   = BUS;
                end
            end
            BUS: begin
                if (wb_stb_o && wb_err_i) begin
                    done        = 1'b1;
                    done_status = ST_ERR;
                end else if (wb_stb_o && wb_rty_i) begin
                    if (rty_cnt < RTY_MAX) begin
                        cyc_nxt     = 1'b0;
                        stb_nxt     = 1'b0;
                        rty_cnt_nxt = rty_cnt + 4'd1;
                        state_nxt   = GAP;
                    end else begin
                        done        = 1'b1;
                        done_status = ST_RETRY;
                    end
                end else if (wb_stb_o && wb_ack_i) begin
                    done        = 1'b1;
                    done_status = ST_OK;
                    done_dat    = wb_we_o ? '0 : wb_dat_i;
                end else if (to_cnt == TO_LAST) begin
                    done        = 1'b1;
                    done_status = ST_TIMEOUT;
                end else begin
                    to_cnt_nxt = to_cnt + 8'd1;
                end
            end
            GAP: begin
                cyc_nxt    = 1'b1;
                stb_nxt    = 1'b1;
                to_cnt_nxt = '0;
                state_nxt  = BUS;
            end
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            cyc_nxt        = 1'b0;
            stb_nxt        = 1'b0;
            rsp_valid_nxt  = 1'b1;
            rsp_status_nxt = done_status;
            rsp_dat_nxt    = done_dat;
            state_nxt      = IDLE;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= IDLE;
            to_cnt     <= '0;
            rty_cnt    <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= '0;
        end else begin
            state      <= state_nxt;
            to_cnt     <= to_cnt_nxt;
            rty_cnt    <= rty_cnt_nxt;
            wb_cyc_o   <= cyc_nxt;
            wb_stb_o   <= stb_nxt;
            wb_we_o    <= we_nxt;
            wb_adr_o   <= adr_nxt;
            wb_dat_o   <= dat_nxt;
            wb_sel_o   <= sel_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_dat    <= rsp_dat_nxt;
            rsp_status <= rsp_status_nxt;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scoreboard bench for wb_cmd_master with a small
// configurable Wishbone slave (ack/err/none, wait states, retry windows).
module tb_wb_cmd_master;

    localparam int DW = 32;
    localparam int AW = 32;

    logic           wb_clk = 1'b0;
    logic           wb_rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_we;
    logic [AW-1:0]  cmd_adr;
    logic [DW-1:0]  cmd_dat;
    logic [3:0]     cmd_sel;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_dat;
    logic [1:0]     rsp_status;
    logic [AW-1:0]  wb_adr_o;
    logic [DW-1:0]  wb_dat_o;
    logic [3:0]     wb_sel_o;
    logic           wb_we_o;
    logic           wb_cyc_o;
    logic           wb_stb_o;
    logic [2:0]     wb_cti_o;
    logic [1:0]     wb_bte_o;
    logic [DW-1:0]  wb_dat_i;
    logic           wb_ack_i;
    logic           wb_err_i;
    logic           wb_rty_i;

    wb_cmd_master #(.dw(DW), .aw(AW), .TIMEOUT(16), .MAX_RETRY(3)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 wb_clk = ~wb_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    status;
        logic [DW-1:0] dat;
    } exp_t;
    exp_t sb[$];

    // Slave configuration: kind 0 ack, 1 err, 2 never terminate, 3 ack+err
    int            slave_kind = 0;
    int            ack_wait   = 0;
    int            rty_limit  = 0;
    int            slave_cnt  = 0;
    int            win_idx    = 0;
    logic [DW-1:0] mem [0:15];
    logic          term_now;

    assign term_now = wb_stb_o && (slave_cnt == ack_wait);
    assign wb_rty_i = term_now && (win_idx < rty_limit);
    assign wb_ack_i = term_now && !wb_rty_i && (slave_kind == 0 || slave_kind == 3);
    assign wb_err_i = term_now && !wb_rty_i && (slave_kind == 1 || slave_kind == 3);
    assign wb_dat_i = mem[wb_adr_o[5:2]];

    // Slave wait-state counter, retry-window counter and write memory
    always @(posedge wb_clk) begin
        if (!wb_stb_o || wb_ack_i || wb_err_i || wb_rty_i) slave_cnt <= 0;
        else slave_cnt <= slave_cnt + 1;
        if (wb_stb_o && wb_rty_i) win_idx <= win_idx + 1;
        if (wb_stb_o && wb_ack_i && wb_we_o) mem[wb_adr_o[5:2]] <= wb_dat_o;
    end

    int cyc_num = 0;
    always @(posedge wb_clk) cyc_num <= cyc_num + 1;

    // Bus monitor: counts strobe windows/cycles, bad inter-retry gaps and
    // any bus field drifting away from the command being executed.
    logic [AW-1:0] exp_adr = '0;
    logic [DW-1:0] exp_dat = '0;
    logic [3:0]    exp_sel = '0;
    logic          exp_we  = 1'b0;
    int win_cnt = 0, stb_cycles = 0, gap_bad = 0, field_bad = 0, rsp_count = 0;
    int low_run = 0;
    bit prev_stb = 1'b0, cmd_open = 1'b0;
    always @(negedge wb_clk) begin
        if (wb_rst) begin
            cmd_open = 1'b0;
            prev_stb = 1'b0;
            low_run  = 0;
        end else begin
            if (wb_stb_o) begin
                if (!prev_stb) begin
                    win_cnt++;
                    if (cmd_open && low_run != 1) gap_bad++;
                    cmd_open = 1'b1;
                end
                stb_cycles++;
                if (wb_adr_o !== exp_adr || wb_dat_o !== exp_dat ||
                    wb_sel_o !== exp_sel || wb_we_o !== exp_we || wb_cyc_o !== 1'b1)
                    field_bad++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (rsp_valid) begin
                rsp_count++;
                cmd_open = 1'b0;
            end
            prev_stb = wb_stb_o;
        end
    end

    task automatic step();
        @(negedge wb_clk);
        #1;
    endtask

    task automatic issue_cmd(input logic we, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat, output int acc_cyc);
        exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = 4'hF;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                acc_cyc = cyc_num;
                break;
            end
            step();
        end
        checks++;
        if (acc_cyc < 0) begin
            errors++;
            $display("[TB] FAIL accept: cmd_ready never high, required 1");
        end else begin
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int rsp_cyc);
        exp_t e;
        rsp_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (rsp_valid) begin
                rsp_cyc = cyc_num;
                break;
            end
        end
        checks++;
        if (rsp_cyc < 0) begin
            errors++;
            $display("[TB] FAIL rsp_timeout: no rsp_valid within %0d cycles", budget);
            return;
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_with_rsp: cmd_ready=%b required 0", cmd_ready);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_rsp: status=%b with empty scoreboard", rsp_status);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_status !== e.status) begin
            errors++;
            $display("[TB] FAIL rsp_status: got %b required %b", rsp_status, e.status);
        end
        checks++;
        if (rsp_dat !== e.dat) begin
            errors++;
            $display("[TB] FAIL rsp_dat: got %h required %h", rsp_dat, e.dat);
        end
    endtask

    task automatic test_reset();
        wb_rst = 1'b1; cmd_valid = 1'b0;
        cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) step();
        checks++;
        if ({cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: rdy/cyc/stb/we/rv=%b required 00000",
                     {cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid});
        end
        checks++;
        if (wb_adr_o !== '0 || wb_dat_o !== '0 || wb_sel_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus: adr=%h dat=%h sel=%h required 0", wb_adr_o, wb_dat_o, wb_sel_o);
        end
        checks++;
        if (rsp_dat !== '0 || rsp_status !== 2'b00 || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_rsp: dat=%h st=%b cti=%b bte=%b required 0",
                     rsp_dat, rsp_status, wb_cti_o, wb_bte_o);
        end
        wb_rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int acc, rc, w0, s0, f0;
        slave_kind = 0; ack_wait = 1; rty_limit = win_idx;
        w0 = win_cnt; s0 = stb_cycles; f0 = field_bad;
        sb.push_back('{2'b00, 32'h0});
        issue_cmd(1'b1, 32'h4, 32'hDEADBEEF, acc);
        wait_rsp(40, rc);
        checks++;
        if (win_cnt - w0 != 1 || stb_cycles - s0 != 2) begin
            errors++;
            $display("[TB] FAIL write_window: windows=%0d stb_cycles=%0d required 1/2",
                     win_cnt - w0, stb_cycles - s0);
        end
        checks++;
        if (field_bad != f0) begin
            errors++;
            $display("[TB] FAIL write_fields: unstable bus fields %0d required 0", field_bad - f0);
        end
    endtask

    task automatic test_read_latency();
        int acc, rc;
        slave_kind = 0; ack_wait = 0; rty_limit = win_idx;
        sb.push_back('{2'b00, 32'hDEADBEEF});
        issue_cmd(1'b0, 32'h4, 32'h0, acc);
        wait_rsp(40, rc);
        checks++;
        if (rc - acc != 2) begin
            errors++;
            $display("[TB] FAIL read_latency: got %0d required 2", rc - acc);
        end
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_dat !== 32'hDEADBEEF || rsp_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rsp_hold: rv=%b dat=%h st=%b required 0/deadbeef/00",
                     rsp_valid, rsp_dat, rsp_status);
        end
    endtask

    task automatic test_timeout();
        int acc, rc, w0, s0;
        slave_kind = 2; ack_wait = 0; rty_limit = win_idx;
        w0 = win_cnt; s0 = stb_cycles;
        sb.push_back('{2'b10, 32'h0});
        issue_cmd(1'b1, 32'h10, 32'h55AA55AA, acc);
        wait_rsp(60, rc);
        checks++;
        if (stb_cycles - s0 != 16 || win_cnt - w0 != 1) begin
            errors++;
            $display("[TB] FAIL timeout_len: stb_cycles=%0d windows=%0d required 16/1",
                     stb_cycles - s0, win_cnt - w0);
        end
        checks++;
        if (wb_cyc_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_cyc: got %b required 0", wb_cyc_o);
        end
    endtask

    task automatic test_retry();
        int acc, rc, w0, g0, f0;
        slave_kind = 0; ack_wait = 0; rty_limit = win_idx + 2;
        w0 = win_cnt; g0 = gap_bad; f0 = field_bad;
        sb.push_back('{2'b00, 32'h0});
        issue_cmd(1'b1, 32'h8, 32'h12345678, acc);
        wait_rsp(60, rc);
        checks++;
        if (win_cnt - w0 != 3 || gap_bad != g0 || field_bad != f0) begin
            errors++;
            $display("[TB] FAIL retry_ok: windows=%0d bad_gaps=%0d bad_fields=%0d required 3/0/0",
                     win_cnt - w0, gap_bad - g0, field_bad - f0);
        end
        rty_limit = 32'h4000_0000;
        w0 = win_cnt; g0 = gap_bad;
        sb.push_back('{2'b11, 32'h0});
        issue_cmd(1'b0, 32'h8, 32'h0, acc);
        wait_rsp(60, rc);
        checks++;
        if (win_cnt - w0 != 4 || gap_bad != g0) begin
            errors++;
            $display("[TB] FAIL retry_exhaust: windows=%0d bad_gaps=%0d required 4/0",
                     win_cnt - w0, gap_bad - g0);
        end
        rty_limit = win_idx;
    endtask

    task automatic test_ack_err();
        int acc, rc;
        slave_kind = 3; ack_wait = 0; rty_limit = win_idx;
        sb.push_back('{2'b01, 32'h0});
        issue_cmd(1'b0, 32'h4, 32'h0, acc);
        wait_rsp(40, rc);
    endtask

    task automatic test_back_to_back();
        int acc1, rc1, acc2, rc2;
        slave_kind = 0; ack_wait = 0; rty_limit = win_idx;
        sb.push_back('{2'b00, 32'h0});
        sb.push_back('{2'b00, 32'hA5A5C3C3});
        issue_cmd(1'b1, 32'hC, 32'hA5A5C3C3, acc1);
        wait_rsp(40, rc1);
        issue_cmd(1'b0, 32'hC, 32'h0, acc2);
        checks++;
        if (acc2 - rc1 != 1) begin
            errors++;
            $display("[TB] FAIL b2b_accept: accepted %0d cycles after rsp required 1", acc2 - rc1);
        end
        wait_rsp(40, rc2);
    endtask

    task automatic test_reset_mid();
        int acc, r0;
        slave_kind = 2; ack_wait = 0; rty_limit = win_idx;
        r0 = rsp_count;
        issue_cmd(1'b1, 32'h14, 32'h0BADF00D, acc);
        repeat (3) step();
        checks++;
        if (wb_stb_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_setup: stb=%b required 1", wb_stb_o);
        end
        wb_rst = 1'b1;
        step();
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: cyc=%b stb=%b rv=%b rdy=%b required 0000",
                     wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready);
        end
        wb_rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_release: rdy=%b rv=%b required 1/0", cmd_ready, rsp_valid);
        end
        repeat (2) step();
        checks++;
        if (rsp_count != r0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_no_rsp: rsp pulses=%0d pending=%0d required 0/0",
                     rsp_count - r0, sb.size());
        end
    endtask

    // Hard stop in case something wedges the sequence below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        test_reset();
        test_write();
        test_read_latency();
        test_timeout();
        test_retry();
        test_ack_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
